// File: rtl/tap_frame_controller.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tap_frame_controller: frames JTAG user-DR words into length-prefixed     |
// | byte payloads with a small FIFO and a valid/ready output. Rev 1.0        |
// +--------------------------------------------------------------------------+
module tap_frame_controller #(
    parameter int DATA_WIDTH = 8,
    parameter int LEN_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  tck,
    input  logic                  test_logic_reset,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  frame_done,
    output logic                  overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        LEN_LO  = 2'd0,
        LEN_HI  = 2'd1,
        PAYLOAD = 2'd2,
        DRAIN   = 2'd3
    } state_t;

    state_t                  state;
    logic [DATA_WIDTH-1:0]   len_lo;
    logic [LEN_WIDTH-1:0]    remain;
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic [DATA_WIDTH:0]     mem [FIFO_DEPTH];

    logic                    empty;
    logic                    full;
    logic                    pop;
    logic                    push_req;
    logic                    push_ok;
    logic                    push_last;
    logic [DATA_WIDTH:0]     head;
    logic [LEN_WIDTH-1:0]    full_len;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop       = !empty && out_ready;
    assign push_req  = (state == PAYLOAD) && in_valid;
    assign push_ok   = push_req && (!full || pop);
    assign push_last = (remain == LEN_WIDTH'(1));
    assign full_len  = LEN_WIDTH'({in_data, len_lo});

    assign head      = mem[rd_ptr[AW-1:0]];
    assign out_valid = !empty;
    assign out_data  = head[DATA_WIDTH-1:0];
    assign out_last  = !empty && head[DATA_WIDTH];

    always_ff @(posedge tck) begin
        if (push_ok) begin
            mem[wr_ptr[AW-1:0]] <= {push_last, in_data};
        end
    end

    always_ff @(posedge tck) begin
        if (test_logic_reset) begin
            state      <= LEN_LO;
            len_lo     <= '0;
            remain     <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            frame_done <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push_req && !push_ok) begin
                overflow <= 1'b1;
            end
            case (state)
                LEN_LO: begin
                    if (in_valid) begin
                        len_lo <= in_data;
                        state  <= LEN_HI;
                    end
                end
                LEN_HI: begin
                    if (in_valid) begin
                        remain <= full_len;
                        if (full_len == '0) begin
                            frame_done <= 1'b1;
                            state      <= LEN_LO;
                        end else begin
                            state <= PAYLOAD;
                        end
                    end
                end
                PAYLOAD: begin
                    // Dropped bytes leave remain untouched so the frame ends on received data.
                    if (push_ok) begin
                        remain <= remain - 1'b1;
                        if (push_last) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (pop && out_last) begin
                        frame_done <= 1'b1;
                        state      <= LEN_LO;
                    end
                end
                default: state <= LEN_LO;
            endcase
        end
    end

endmodule
`default_nettype wire
